// File: rtl/sig_control_timed.sv
// Timed highway/country traffic signal controller with pedestrian walk.
// Highway has priority; country green is bounded by min/max timers.
module sig_control_timed #(
    parameter int MIN_HWY_GREEN   = 8,
    parameter int YELLOW_TIME     = 3,
    parameter int ALL_RED_TIME    = 2,
    parameter int MIN_CNTRY_GREEN = 4,
    parameter int MAX_CNTRY_GREEN = 10,
    parameter int TIMER_W         = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HG   = 3'd0,
        HY   = 3'd1,
        AR1  = 3'd2,
        CG   = 3'd3,
        CY   = 3'd4,
        AR2  = 3'd5,
        BAD6 = 3'd6,
        BAD7 = 3'd7
    } state_e;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    localparam logic [TIMER_W-1:0] T_HG_MIN = TIMER_W'(MIN_HWY_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_YEL    = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] T_AR     = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] T_CG_MIN = TIMER_W'(MIN_CNTRY_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_CG_MAX = TIMER_W'(MAX_CNTRY_GREEN - 1);
    localparam logic [TIMER_W-1:0] CNT_SAT  = '1;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               ped_q, ped_d;

    logic hwy_ready;
    logic cg_done;

    assign hwy_ready = (cnt_q >= T_HG_MIN) && (X || ped_q);
    assign cg_done   = ((cnt_q >= T_CG_MIN) && !X) || (cnt_q == T_CG_MAX);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= HG;
            cnt_q   <= '0;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ped_q   <= ped_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HG:  if (hwy_ready)      state_d = HY;
            HY:  if (cnt_q == T_YEL) state_d = AR1;
            AR1: if (cnt_q == T_AR)  state_d = CG;
            CG:  if (cg_done)        state_d = CY;
            CY:  if (cnt_q == T_YEL) state_d = AR2;
            AR2: if (cnt_q == T_AR)  state_d = HG;
            default:                 state_d = HG;
        endcase
    end

    // Phase timer restarts on any state change and saturates otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Entering CG serves the request; that clear beats a same-edge press.
    always_comb begin
        ped_d = ped_q;
        if (ped_req && (state_q != CG)) begin
            ped_d = 1'b1;
        end
        if ((state_d == CG) && (state_q != CG)) begin
            ped_d = 1'b0;
        end
    end

    always_comb begin
        hwy   = RED;
        cntry = RED;
        walk  = 1'b0;
        unique case (state_q)
            HG: hwy = GREEN;
            HY: hwy = YELLOW;
            CG: begin
                cntry = GREEN;
                walk  = 1'b1;
            end
            CY: cntry = YELLOW;
            default: begin
                hwy   = RED;
                cntry = RED;
            end
        endcase
    end

    assign phase       = state_q;
    assign ped_pending = ped_q;

endmodule

// File: tb/tb_sig_control_timed.sv
// Directed-vector bench for sig_control_timed at default parameters.
// Samples are taken 1 time unit after each rising edge.
module tb_sig_control_timed;

    logic       clock;
    logic       clear;
    logic       X;
    logic       ped_req;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    int checks;
    int failures;

    logic [2:0] ph_s   [0:127];
    logic [1:0] hwy_s  [0:127];
    logic [1:0] cntry_s[0:127];
    logic       walk_s [0:127];
    logic       ped_s  [0:127];

    int rl[0:127];
    int rp[0:127];

    sig_control_timed dut (
        .clock      (clock),
        .clear      (clear),
        .X          (X),
        .ped_req    (ped_req),
        .hwy        (hwy),
        .cntry      (cntry),
        .walk       (walk),
        .ped_pending(ped_pending),
        .phase      (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Leaves clear low between edges; the next edge is cycle 0.
    task automatic do_reset();
        clear   = 1'b1;
        X       = 1'b0;
        ped_req = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    // Edge k sees X=(xf<=k<=xt) and ped_req=(k==pat).
    task automatic run(input int n, input int xf, input int xt,
                       input int pat);
        for (int k = 0; k < n; k++) begin
            X       = (k >= xf) && (k <= xt);
            ped_req = (k == pat);
            @(posedge clock);
            #1;
            ph_s[k]    = phase;
            hwy_s[k]   = hwy;
            cntry_s[k] = cntry;
            walk_s[k]  = walk;
            ped_s[k]   = ped_pending;
        end
        X       = 1'b0;
        ped_req = 1'b0;
    endtask

    function automatic int exp_hwy(input logic [2:0] p);
        case (p)
            3'd0:    return 2;
            3'd1:    return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_cntry(input logic [2:0] p);
        case (p)
            3'd3:    return 2;
            3'd4:    return 1;
            default: return 0;
        endcase
    endfunction

    initial begin
        int bad;
        int nr;
        int exp_len[12];
        int exp_ph[12];
        checks   = 0;
        failures = 0;
        clear    = 1'b1;
        X        = 1'b0;
        ped_req  = 1'b0;

        // Reset state
        do_reset();
        check("rst_hwy", hwy, 2);
        check("rst_cntry", cntry, 0);
        check("rst_walk", walk, 0);
        check("rst_ped", ped_pending, 0);
        check("rst_phase", phase, 0);

        // Idle
        run(100, 1, 0, -1);
        bad = 0;
        for (int k = 0; k < 100; k++)
            if (hwy_s[k] != 2 || cntry_s[k] != 0 || walk_s[k] != 0)
                bad++;
        check("idle_lamps", bad, 0);

        // Car held: 8/3/2/10/3/2 repeating
        do_reset();
        run(60, 0, 1000, -1);
        exp_len = '{7, 3, 2, 10, 3, 2, 8, 3, 2, 10, 3, 2};
        exp_ph  = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
        nr    = 0;
        rl[0] = 1;
        rp[0] = int'(ph_s[0]);
        for (int k = 1; k < 60; k++) begin
            if (ph_s[k] == ph_s[k-1]) begin
                rl[nr]++;
            end else begin
                nr++;
                rl[nr] = 1;
                rp[nr] = int'(ph_s[k]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            check($sformatf("car_len%0d", i), rl[i], exp_len[i]);
            check($sformatf("car_ph%0d", i), rp[i], exp_ph[i]);
        end
        bad = 0;
        for (int k = 0; k < 60; k++)
            if (hwy_s[k] != exp_hwy(ph_s[k]) ||
                cntry_s[k] != exp_cntry(ph_s[k]) ||
                walk_s[k] != (ph_s[k] == 3'd3) || ped_s[k] != 0)
                bad++;
        check("car_lamps", bad, 0);

        // Short car: no transition
        do_reset();
        run(30, 0, 3, -1);
        bad = 0;
        for (int k = 0; k < 30; k++)
            if (ph_s[k] != 0 || hwy_s[k] != 2) bad++;
        check("short_car", bad, 0);

        // Pedestrian request at cycle 2
        do_reset();
        run(41, 1, 0, 2);
        check("ped_before", ped_s[1], 0);
        check("ped_latched", ped_s[2], 1);
        check("ped_hg_last", ph_s[6], 0);
        check("ped_hy", ph_s[7], 1);
        check("ped_ar1_pend", ped_s[11], 1);
        check("ped_cg", ph_s[12], 3);
        check("ped_cg_clr", ped_s[12], 0);
        check("ped_cg_walk", walk_s[12], 1);
        bad = 0;
        for (int k = 0; k < 41; k++) if (walk_s[k]) bad++;
        check("ped_walk_len", bad, 4);
        check("ped_cy", ph_s[16], 4);
        check("ped_hg_back", ph_s[21], 0);
        check("ped_hg_hold", ph_s[40], 0);

        // Ped press during CG cycle 1 with X held through edge 16
        do_reset();
        run(50, 0, 16, 13);
        check("pcg_in_cg", ph_s[13], 3);
        bad = 0;
        for (int k = 0; k < 50; k++) if (ped_s[k]) bad++;
        check("pcg_no_latch", bad, 0);
        check("pcg_cy", ph_s[17], 4);
        check("pcg_ar2", ph_s[21], 5);
        bad = 0;
        for (int k = 22; k < 50; k++) if (ph_s[k] != 0) bad++;
        check("pcg_hg_hold", bad, 0);

        // Clear while a request is pending
        do_reset();
        run(4, 1, 0, 2);
        check("clr_pend_pre", ped_pending, 1);
        #2;
        clear = 1'b1;
        #1;
        check("clr_pend", ped_pending, 0);
        clear = 1'b0;

        // Async clear mid-CG, between edges
        do_reset();
        run(15, 0, 1000, -1);
        check("ar_pre_cg", phase, 3);
        #2;
        clear = 1'b1;
        #1;
        check("ar_hwy", hwy, 2);
        check("ar_cntry", cntry, 0);
        check("ar_walk", walk, 0);
        check("ar_ped", ped_pending, 0);
        check("ar_phase", phase, 0);
        clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
